// File: rtl/mem_row_reader.sv
// mem_row_reader
// Read-side master for the grid memory bank. A sweep walks rows
// start_row .. end_row-1 and, inside each row, column chunks 0, TX, 2TX, ...
// up to LAST_COL. Each chunk is fetched with a single read_en/ack request
// and then offered to a consumer on a valid/ready stream. There is at most
// one outstanding read, and there is no prefetch.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   sweep_start             : one-cycle start pulse, honoured in IDLE or DONE only
//   busy_in                 : bank busy; holds off a new request while in ARB
//   ack_in, partial_vec_in  : bank acknowledge with its read data (same cycle)
//   read_en_out             : read request to the bank
//   row_addr_out            : row of the request
//   col_addr_out            : column base (chunk start) of the request
//   out_valid, out_ready    : output stream handshake
//   out_vec                 : chunk data; bit i is column out_col+i
//   out_row, out_col        : tags of the chunk
//   out_last_col            : chunk is the last one of its row
//   out_last_row            : chunk belongs to row end_row-1
//   done_out                : one-cycle pulse after the final chunk is accepted
// All outputs come from registers. No combinational path runs from ack_in or
// out_ready to an output.

module mem_row_reader #(
  parameter int TX_DATA_WIDTH   = 8,
  parameter int BANK_ADDR_WIDTH = 4,
  parameter int COL_ADDR_WIDTH  = 6,
  parameter int MAX_COLS        = 20,
  parameter int start_row       = 0,
  parameter int end_row         = 2 ** BANK_ADDR_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sweep_start,
  input  logic                       busy_in,
  input  logic                       ack_in,
  input  logic [TX_DATA_WIDTH-1:0]   partial_vec_in,
  output logic                       read_en_out,
  output logic [BANK_ADDR_WIDTH-1:0] row_addr_out,
  output logic [COL_ADDR_WIDTH-1:0]  col_addr_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TX_DATA_WIDTH-1:0]   out_vec,
  output logic [BANK_ADDR_WIDTH-1:0] out_row,
  output logic [COL_ADDR_WIDTH-1:0]  out_col,
  output logic                       out_last_col,
  output logic                       out_last_row,
  output logic                       done_out
);

  localparam int LAST_COL_INT = ((MAX_COLS - 1) / TX_DATA_WIDTH) * TX_DATA_WIDTH;
  localparam logic [COL_ADDR_WIDTH-1:0]  LAST_COL  = COL_ADDR_WIDTH'(LAST_COL_INT);
  localparam logic [COL_ADDR_WIDTH-1:0]  COL_STEP  = COL_ADDR_WIDTH'(TX_DATA_WIDTH);
  localparam logic [BANK_ADDR_WIDTH-1:0] FIRST_ROW = BANK_ADDR_WIDTH'(start_row);
  localparam logic [BANK_ADDR_WIDTH-1:0] LAST_ROW  = BANK_ADDR_WIDTH'(end_row - 1);
  localparam logic [BANK_ADDR_WIDTH-1:0] ROW_ONE   = BANK_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_OUT,
    S_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0]   row_q, row_d;
  logic [COL_ADDR_WIDTH-1:0]    col_q, col_d;
  logic                         read_en_d;
  logic                         valid_d;
  logic                         done_d;
  logic                         capture;
  logic [TX_DATA_WIDTH-1:0]     tail_mask;

  // The request address is simply the sweep position. The counters advance
  // only on an output handshake, so the address is stable for the whole of REQ.
  assign row_addr_out = row_q;
  assign col_addr_out = col_q;

  // Column bits at or beyond MAX_COLS carry no data. Only the last chunk of a
  // row can contain such bits.
  always_comb begin
    for (int i = 0; i < TX_DATA_WIDTH; i++) begin
      tail_mask[i] = (32'(col_q) + 32'(i)) < 32'(MAX_COLS);
    end
  end

  always_comb begin
    // NOTE: every signal this block drives gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    read_en_d = read_en_out;
    valid_d   = out_valid;
    done_d    = 1'b0;
    capture   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (sweep_start) begin
          row_d   = FIRST_ROW;
          col_d   = '0;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (!busy_in) begin
          read_en_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // busy_in is ignored here. Once issued, the request stays up until ack.
        if (ack_in) begin
          capture   = 1'b1;
          read_en_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (col_q < LAST_COL) begin
            col_d   = col_q + COL_STEP;
            state_d = S_ARB;
          end else if (row_q < LAST_ROW) begin
            row_d   = row_q + ROW_ONE;
            col_d   = '0;
            state_d = S_ARB;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the output data registers are reset as well as the control
      // state, because their reset values are visible on the ports.
      state_q      <= S_IDLE;
      row_q        <= FIRST_ROW;
      col_q        <= '0;
      read_en_out  <= 1'b0;
      out_valid    <= 1'b0;
      done_out     <= 1'b0;
      out_vec      <= '0;
      out_row      <= '0;
      out_col      <= '0;
      out_last_col <= 1'b0;
      out_last_row <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, whatever order the statements appear in.
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      read_en_out <= read_en_d;
      out_valid   <= valid_d;
      done_out    <= done_d;
      if (capture) begin
        out_vec      <= partial_vec_in & tail_mask;
        out_row      <= row_q;
        out_col      <= col_q;
        out_last_col <= (col_q == LAST_COL);
        out_last_row <= (row_q == LAST_ROW);
      end
    end
  end

endmodule
